// File: rtl/interp_collector_pkg.sv
// ---------------------------------------------------------------------------
// interp_collector_pkg
// Shared definitions for the interpolation-result collector: FSM state
// encodings, default output grid size and the address / sum widths used by
// interp_collector and its address generator.
// ---------------------------------------------------------------------------
package interp_collector_pkg;

  // Collector FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Default output grid (17 x 17 samples)
  localparam int OUT_W_DEF = 17;
  localparam int OUT_H_DEF = 17;

  // Result-RAM address width and frame sum width (289 * 255 fits in 17 bits)
  localparam int ADDR_W = 9;
  localparam int SUM_W  = 17;

endpackage

// File: rtl/collect_addr_gen.sv
// ---------------------------------------------------------------------------
// collect_addr_gen
// Row/column counter for the result grid. The column advances on every
// accepted sample and wraps at OUT_W-1, bumping the row. The write address
// row*OUT_W+col is produced combinationally from the current counters, so
// the top level latches it together with the sample it belongs to.
//
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   clr_i   : clear row and column (new frame / restart)
//   adv_i   : advance one sample position
//   addr_o  : row*OUT_W+col for the current position
// ---------------------------------------------------------------------------
module collect_addr_gen
  import interp_collector_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF,
  parameter int OUT_H = OUT_H_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] addr_o
);

  localparam int COL_W = $clog2(OUT_W);
  // Row needs to reach OUT_H after the final wrap of a frame
  localparam int ROW_W = $clog2(OUT_H + 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Next position: clear has priority over advance; column wraps into row
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (adv_i) begin
      if (col_q == COL_W'(OUT_W - 1)) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Position registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign addr_o = ADDR_W'(row_q) * ADDR_W'(OUT_W) + ADDR_W'(col_q);

endmodule

// File: rtl/interp_collector.sv
// ---------------------------------------------------------------------------
// interp_collector
// Collects one OUT_W x OUT_H frame of samples from an interpolation stream
// into a result RAM. START arms a frame; each valid sample in COLLECT is
// written one cycle later at row*OUT_W+col and added into SUM. After the
// last sample the FSM spends one cycle in DONE (DONE=1, coincident with the
// final write) and returns to IDLE. Samples outside COLLECT and START during
// COLLECT raise the sticky ERR flag.
//
// Ports
//   clk     : clock, rising edge
//   RST     : asynchronous active-high reset
//   START   : one-cycle pulse, arms (or restarts) a frame
//   I_DATA  : 8-bit sample
//   I_VALID : I_DATA valid this cycle (no backpressure)
//   WEN     : result-RAM write enable, active low
//   W_ADDR  : result-RAM address
//   W_DATA  : result-RAM write data
//   DONE    : one-cycle frame-complete pulse
//   ERR     : sticky protocol error
//   SUM     : sum of the frame's samples
// ---------------------------------------------------------------------------
module interp_collector
  import interp_collector_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF,
  parameter int OUT_H = OUT_H_DEF
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              START,
  input  logic [7:0]        I_DATA,
  input  logic              I_VALID,
  output logic              WEN,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              DONE,
  output logic              ERR,
  output logic [SUM_W-1:0]  SUM
);

  localparam int                TOTAL    = OUT_W * OUT_H;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TOTAL - 1);

  state_t              state_q;
  logic [ADDR_W-1:0]   count_q;
  logic                wen_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [7:0]          wdata_q;
  logic                err_q;
  logic [SUM_W-1:0]    sum_q;

  logic                accept;
  logic                clear;
  logic [ADDR_W-1:0]   cur_addr;

  // A sample is taken only in COLLECT and only when no START competes with
  // it; START clears the position in IDLE and COLLECT but not in DONE.
  always_comb begin
    accept = (state_q == ST_COLLECT) && I_VALID && !START;
    clear  = START && (state_q != ST_DONE);
  end

  collect_addr_gen #(
    .OUT_W (OUT_W),
    .OUT_H (OUT_H)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (RST),
    .clr_i  (clear),
    .adv_i  (accept),
    .addr_o (cur_addr)
  );

  // Main FSM with registered write port, sum and error flag. WEN defaults
  // high every cycle and drops only for the cycle after an accepted sample;
  // address and data hold their last values otherwise.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      wen_q   <= 1'b1;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      sum_q   <= '0;
    end else begin
      wen_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            state_q <= ST_COLLECT;
            count_q <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
          end else if (I_VALID) begin
            err_q <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (START) begin
            // Restart: flag it, drop any coincident sample, begin again
            err_q   <= 1'b1;
            count_q <= '0;
            sum_q   <= '0;
          end else if (I_VALID) begin
            wen_q   <= 1'b0;
            waddr_q <= cur_addr;
            wdata_q <= I_DATA;
            sum_q   <= sum_q + SUM_W'(I_DATA);
            count_q <= count_q + ADDR_W'(1);
            if (count_q == LAST_IDX) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          if (I_VALID) begin
            err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign WEN    = wen_q;
  assign W_ADDR = waddr_q;
  assign W_DATA = wdata_q;
  assign DONE   = (state_q == ST_DONE);
  assign ERR    = err_q;
  assign SUM    = sum_q;

endmodule
